pc_sequencer_module: RTL

- Control sequencer for `pc_increment_v2_module`. It drives that block's `increment` strobe and its `load` / `is_BSR` / `is_RET` / `D` / `S` / `stack_in` inputs from decoded instruction flags.
- It owns the hardware return-address stack (RAS): push on BSR, pop on RET.
- It guarantees every PC control input is stable one full cycle before the PC's rising strobe edge.
- It flags stack overflow and underflow, and halts on either.

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/pc_sequencer_module_ras.sv | 55 +++++
 rtl/pc_sequencer_module.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC control sequencer.
// Holds the state encoding, default widths and select-vector bit positions.
package pc_seq_pkg;

    localparam int PC_W_DEF  = 11;
    localparam int OFS_W_DEF = 10;
    localparam int DEPTH_DEF = 8;

    // One bit per PC mux select; all zero means plain increment.
    localparam int SEL_W    = 3;
    localparam int SEL_LOAD = 0;
    localparam int SEL_BSR  = 1;
    localparam int SEL_RET  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_STEP  = 2'd2,
        ST_FAULT = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_module_ras.sv
// Return-address stack: DEPTH x PC_W storage with an occupancy counter.
// Pushes and pops are ignored when full or empty respectively; rdata_top is combinational.
module ras_stack_module #(
    parameter int PC_W  = 11,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [PC_W-1:0]              wdata,
    output logic [PC_W-1:0]              rdata_top,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   sp
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_W-1:0] mem_q [DEPTH];
    logic [SPW-1:0]  sp_q, sp_d;
    logic [SPW-1:0]  top_idx;

    assign full      = (sp_q == SPW'(DEPTH));
    assign empty     = (sp_q == '0);
    assign top_idx   = sp_q - SPW'(1);
    // Only meaningful when not empty; the caller checks empty first.
    assign rdata_top = mem_q[top_idx[AW-1:0]];
    assign sp        = sp_q;

    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[sp_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/pc_sequencer_module.sv
// Sequencer driving the PC block: captures one decoded op in IDLE, then SETUP, then a one-cycle STEP strobe.
// Selects are registered at capture so they settle a full cycle before pc_step; overflow/underflow park it in FAULT.
module pc_sequencer_module
    import pc_seq_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int OFS_W = OFS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        run,
    input  logic                        mem_ready,
    input  logic                        op_jump,
    input  logic                        op_bsr,
    input  logic                        op_ret,
    input  logic [PC_W-1:0]             jump_addr,
    input  logic [OFS_W-1:0]            bsr_ofs,
    input  logic [PC_W-1:0]             pc_q,
    output logic                        pc_step,
    output logic                        pc_load,
    output logic                        pc_is_bsr,
    output logic                        pc_is_ret,
    output logic [PC_W-1:0]             pc_d,
    output logic [OFS_W-1:0]            pc_s,
    output logic [PC_W-1:0]             pc_stack_in,
    output logic [$clog2(DEPTH+1)-1:0]  sp,
    output logic                        overflow,
    output logic                        underflow,
    output logic                        halted
);

    seq_state_e        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [PC_W-1:0]   jmp_q, jmp_d;
    logic [OFS_W-1:0]  ofs_q, ofs_d;
    logic [PC_W-1:0]   ret_addr_q, ret_addr_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              step_q, step_d;
    logic              halted_q, halted_d;

    logic              ras_push, ras_pop;
    logic              ras_full, ras_empty;
    logic [PC_W-1:0]   ras_top;

    ras_stack_module #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .wdata     (pc_q + PC_W'(1)),
        .rdata_top (ras_top),
        .full      (ras_full),
        .empty     (ras_empty),
        .sp        (sp)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        jmp_d      = jmp_q;
        ofs_d      = ofs_q;
        ret_addr_d = ret_addr_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (run && mem_ready) begin
                    state_d = ST_SETUP;
                    sel_d   = '0;
                    // Priority bsr > ret > jump mirrors the PC block's own mux.
                    if (op_bsr) begin
                        if (ras_full) begin
                            ovf_d   = 1'b1;
                            state_d = ST_FAULT;
                            sel_d   = sel_q;
                        end else begin
                            ras_push       = 1'b1;
                            ofs_d          = bsr_ofs;
                            sel_d[SEL_BSR] = 1'b1;
                        end
                    end else if (op_ret) begin
                        if (ras_empty) begin
                            unf_d   = 1'b1;
                            state_d = ST_FAULT;
                            sel_d   = sel_q;
                        end else begin
                            ras_pop        = 1'b1;
                            ret_addr_d     = ras_top;
                            sel_d[SEL_RET] = 1'b1;
                        end
                    end else if (op_jump) begin
                        jmp_d           = jump_addr;
                        sel_d[SEL_LOAD] = 1'b1;
                    end
                end
            end
            ST_SETUP: state_d = ST_STEP;
            ST_STEP:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase

        step_d   = (state_d == ST_STEP);
        halted_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            jmp_q      <= '0;
            ofs_q      <= '0;
            ret_addr_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            step_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            jmp_q      <= jmp_d;
            ofs_q      <= ofs_d;
            ret_addr_q <= ret_addr_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            step_q     <= step_d;
            halted_q   <= halted_d;
        end
    end

    assign pc_step     = step_q;
    assign pc_load     = sel_q[SEL_LOAD];
    assign pc_is_bsr   = sel_q[SEL_BSR];
    assign pc_is_ret   = sel_q[SEL_RET];
    assign pc_d        = jmp_q;
    assign pc_s        = ofs_q;
    assign pc_stack_in = ret_addr_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign halted      = halted_q;

endmodule
